// File: rtl/alu_secuencial.sv
// alu_secuencial: registered ALU with enable/listo/valido handshake and shift-add multiply.
// Define ALU_MUL_EN to build the multi-cycle multiplier; otherwise sel=110 yields zero in one cycle.
module alu_secuencial #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             enable,
    output logic             listo,
    output logic [WIDTH-1:0] salida,
    output logic             valido,
    output logic             cero,
    output logic             acarreo
);
    localparam logic [2:0] OP_MUL = 3'b110;

    logic [WIDTH-1:0] salida_d, salida_q;
    logic             valido_d, valido_q;
    logic             cero_d, cero_q;
    logic             acarreo_d, acarreo_q;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // The extra top bit of sum/diff is carry out of ADD and borrow of SUB.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (sel)
            3'b000: alu_res = a & b;
            3'b001: alu_res = a | b;
            3'b010: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            3'b011: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
            end
            3'b100: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            3'b101: alu_res = ~(a | b);
            3'b110: alu_res = '0;
            3'b111: alu_res = a ^ b;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_d, state_q;
    logic [WIDTH-1:0] acc_d, acc_q, mcand_d, mcand_q, mplier_d, mplier_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [WIDTH-1:0] acc_next;

    assign listo    = (state_q == IDLE);
    assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        salida_d  = salida_q;
        cero_d    = cero_q;
        acarreo_d = acarreo_q;
        valido_d  = 1'b0;
        if (state_q == IDLE) begin
            if (enable && sel == OP_MUL) begin
                acc_d    = '0;
                mcand_d  = a;
                mplier_d = b;
                count_d  = CNT_W'(WIDTH);
                state_d  = MUL;
            end else if (enable) begin
                salida_d  = alu_res;
                cero_d    = (alu_res == '0);
                acarreo_d = alu_c;
                valido_d  = 1'b1;
            end
        end else begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - 1'b1;
            if (count_q == CNT_W'(1)) begin
                salida_d  = acc_next;
                cero_d    = (acc_next == '0);
                acarreo_d = 1'b0;
                valido_d  = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            salida_q  <= '0;
            valido_q  <= 1'b0;
            cero_q    <= 1'b1;
            acarreo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            salida_q  <= salida_d;
            valido_q  <= valido_d;
            cero_q    <= cero_d;
            acarreo_q <= acarreo_d;
        end
    end
`else
    assign listo = 1'b1;

    always_comb begin
        salida_d  = enable ? alu_res : salida_q;
        cero_d    = enable ? (alu_res == '0) : cero_q;
        acarreo_d = enable ? alu_c : acarreo_q;
        valido_d  = enable;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            salida_q  <= '0;
            valido_q  <= 1'b0;
            cero_q    <= 1'b1;
            acarreo_q <= 1'b0;
        end else begin
            salida_q  <= salida_d;
            valido_q  <= valido_d;
            cero_q    <= cero_d;
            acarreo_q <= acarreo_d;
        end
    end
`endif

    assign salida  = salida_q;
    assign valido  = valido_q;
    assign cero    = cero_q;
    assign acarreo = acarreo_q;
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed self-checking bench for alu_secuencial (WIDTH=32).
// Multiply checks run when ALU_MUL_EN is defined; otherwise the single-cycle sel=110 path is checked.
module tb_alu_secuencial;
    logic        clk = 1'b0;
    logic        rst_n, enable, listo, valido, cero, acarreo;
    logic [31:0] a, b, salida;
    logic [2:0]  sel;
    int          checks = 0;
    int          failures = 0;

    alu_secuencial #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .enable(enable),
        .listo(listo), .salida(salida), .valido(valido), .cero(cero), .acarreo(acarreo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then drop enable.
    task automatic op(input logic [31:0] oa, input logic [31:0] ob, input logic [2:0] os);
        a = oa;
        b = ob;
        sel = os;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [31:0] s, input logic c, input logic k);
        check({tag, "_salida"}, salida, s);
        check({tag, "_cero"}, {31'b0, cero}, {31'b0, c});
        check({tag, "_acarreo"}, {31'b0, acarreo}, {31'b0, k});
        check({tag, "_valido"}, {31'b0, valido}, 32'd1);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        enable = 1'b0;
        a = '0;
        b = '0;
        sel = '0;
        tick();
        tick();
        check("rst_salida", salida, 32'd0);
        check("rst_cero", {31'b0, cero}, 32'd1);
        check("rst_acarreo", {31'b0, acarreo}, 32'd0);
        check("rst_valido", {31'b0, valido}, 32'd0);
        check("rst_listo", {31'b0, listo}, 32'd1);
        rst_n = 1'b1;

        op(32'd8, 32'd16, 3'b010);
        expect_res("add", 32'd24, 1'b0, 1'b0);
        op(32'd8, 32'd16, 3'b011);
        expect_res("sub", 32'hFFFFFFF8, 1'b0, 1'b1);
        tick();
        check("idle_valido", {31'b0, valido}, 32'd0);
        check("idle_hold", salida, 32'hFFFFFFF8);

        op(32'hFFFFFFFF, 32'd1, 3'b010);
        expect_res("add_ovf", 32'd0, 1'b1, 1'b1);
        op(32'hFFFFFFFE, 32'd3, 3'b100);
        expect_res("slt_neg", 32'd1, 1'b0, 1'b0);
        op(32'd3, 32'hFFFFFFFE, 3'b100);
        expect_res("slt_pos", 32'd0, 1'b1, 1'b0);
        op(32'd0, 32'd0, 3'b101);
        expect_res("nor", 32'hFFFFFFFF, 1'b0, 1'b0);

        op(32'h0000F0F0, 32'h0000FF00, 3'b000);
        expect_res("b2b_and", 32'h0000F000, 1'b0, 1'b0);
        op(32'h0000F0F0, 32'h0000FF00, 3'b001);
        expect_res("b2b_or", 32'h0000FFF0, 1'b0, 1'b0);
        op(32'h0000F0F0, 32'h0000FF00, 3'b111);
        expect_res("b2b_xor", 32'h00000FF0, 1'b0, 1'b0);

`ifdef ALU_MUL_EN
        op(32'd20, 32'd100, 3'b110);
        check("mul_busy_listo", {31'b0, listo}, 32'd0);
        pulses = 0;
        // Hammer enable with an AND during the multiply; none may be accepted.
        for (int i = 1; i < 32; i++) begin
            a = 32'hFFFFFFFF;
            b = 32'h12345678;
            sel = 3'b000;
            enable = 1'b1;
            if (valido || listo) pulses++;
            tick();
        end
        check("mul_busy_quiet", pulses, 32'd0);
        enable = 1'b0;
        check("mul_last_listo", {31'b0, listo}, 32'd0);
        tick();
        expect_res("mul", 32'd2000, 1'b0, 1'b0);
        check("mul_done_listo", {31'b0, listo}, 32'd1);
        tick();
        check("mul_single_pulse", {31'b0, valido}, 32'd0);

        op(32'h00010001, 32'h00010001, 3'b110);
        a = 32'd7;
        b = 32'd9;
        for (int i = 1; i < 32; i++) tick();
        tick();
        expect_res("mul_wrap", 32'h00020001, 1'b0, 1'b0);
        op(32'd1, 32'd2, 3'b010);
        expect_res("mul_then_add", 32'd3, 1'b0, 1'b0);

        op(32'd34, 32'd122, 3'b110);
        for (int i = 1; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_salida", salida, 32'd0);
        check("mrst_valido", {31'b0, valido}, 32'd0);
        check("mrst_listo", {31'b0, listo}, 32'd1);
        check("mrst_cero", {31'b0, cero}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (valido) pulses++;
            tick();
        end
        check("mrst_no_pulse", pulses, 32'd0);
        op(32'd34, 32'd122, 3'b000);
        expect_res("mrst_and", 32'd34, 1'b0, 1'b0);
`else
        op(32'hFFFFFFFF, 32'd2, 3'b010);
        expect_res("pre_mul_add", 32'd1, 1'b0, 1'b1);
        op(32'd20, 32'd100, 3'b110);
        expect_res("nomul", 32'd0, 1'b1, 1'b0);
        check("nomul_listo", {31'b0, listo}, 32'd1);
        op(32'd34, 32'd122, 3'b000);
        expect_res("nomul_and", 32'd34, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
